// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite response codes and FSM state types for the register target.
package axi4lite_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/axi4lite_if.sv
// AXI4-Lite bus bundle with initiator and target views.
interface axi4lite_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
) ();

    logic [AWIDTH-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DWIDTH-1:0]   wdata;
    logic [DWIDTH/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [AWIDTH-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DWIDTH-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport initiator_port (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport target_port (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi4lite_reg_target.sv
// AXI4-Lite register bank with flat register outputs and a hardware write port.
// Optional AXI4LITE_REG_TARGET_PROT_CHECK_EN rejects non-secure accesses to register 0.
module axi4lite_reg_target
    import axi4lite_pkg::*;
#(
    parameter int unsigned      AWIDTH    = 32,
    parameter int unsigned      DWIDTH    = 32,
    parameter int unsigned      NREGS     = 16,
    parameter logic [DWIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    resetn,
    axi4lite_if.target_port         s,
    output logic [NREGS*DWIDTH-1:0] regs_out,
    input  logic                    hw_we,
    input  logic [7:0]              hw_idx,
    input  logic [DWIDTH-1:0]       hw_wdata
);

    localparam int unsigned NBYTES   = DWIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(NBYTES);

    wr_state_t w_state;
    rd_state_t r_state;

    logic [AWIDTH-1:0] aw_addr_q;
    logic [DWIDTH-1:0] w_data_q;
    logic [NBYTES-1:0] w_strb_q;

    logic aw_done_c, w_done_c, b_done_c, ar_done_c, r_done_c;
    logic              wr_fire_c;
    logic [AWIDTH-1:0] wr_addr_c;
    logic [DWIDTH-1:0] wr_data_c;
    logic [NBYTES-1:0] wr_strb_c;
    logic [AWIDTH-1:0] wr_idx_c, rd_idx_c;
    logic              wr_err_c, rd_err_c;
    logic [1:0]        wr_resp_c;
    logic [DWIDTH-1:0] rd_word_c;

    assign aw_done_c = s.awvalid & s.awready;
    assign w_done_c  = s.wvalid  & s.wready;
    assign b_done_c  = s.bvalid  & s.bready;
    assign ar_done_c = s.arvalid & s.arready;
    assign r_done_c  = s.rvalid  & s.rready;

    // Commit happens on whichever edge completes the second of the AW/W handshakes.
    always_comb begin
        wr_fire_c = 1'b0;
        wr_addr_c = aw_addr_q;
        wr_data_c = w_data_q;
        wr_strb_c = w_strb_q;
        case (w_state)
            W_IDLE: begin
                wr_fire_c = aw_done_c & w_done_c;
                wr_addr_c = s.awaddr;
                wr_data_c = s.wdata;
                wr_strb_c = s.wstrb;
            end
            W_HAVE_A: begin
                wr_fire_c = w_done_c;
                wr_data_c = s.wdata;
                wr_strb_c = s.wstrb;
            end
            W_HAVE_D: begin
                wr_fire_c = aw_done_c;
                wr_addr_c = s.awaddr;
            end
            default: ;
        endcase
    end

    assign wr_idx_c = wr_addr_c >> ADDR_LSB;
    assign rd_idx_c = s.araddr >> ADDR_LSB;

`ifdef AXI4LITE_REG_TARGET_PROT_CHECK_EN
    logic [2:0] aw_prot_q;
    logic [2:0] wr_prot_c;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            aw_prot_q <= '0;
        end else if (w_state == W_IDLE && aw_done_c && !w_done_c) begin
            aw_prot_q <= s.awprot;
        end
    end

    assign wr_prot_c = (w_state == W_HAVE_A) ? aw_prot_q : s.awprot;
    assign wr_err_c  = (wr_idx_c >= AWIDTH'(NREGS)) || (wr_prot_c[1] && wr_idx_c == '0);
    assign rd_err_c  = (rd_idx_c >= AWIDTH'(NREGS)) || (s.arprot[1] && rd_idx_c == '0);
`else
    logic unused_prot;
    assign unused_prot = ^{s.awprot, s.arprot};
    assign wr_err_c    = wr_idx_c >= AWIDTH'(NREGS);
    assign rd_err_c    = rd_idx_c >= AWIDTH'(NREGS);
`endif

    assign wr_resp_c = wr_err_c ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

    always_comb begin
        rd_word_c = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (rd_idx_c == AWIDTH'(i)) rd_word_c = regs_out[i*DWIDTH +: DWIDTH];
        end
    end

    // Write channel FSM.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state   <= W_IDLE;
            s.awready <= 1'b0;
            s.wready  <= 1'b0;
            s.bvalid  <= 1'b0;
            s.bresp   <= AXI_RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    s.awready <= 1'b1;
                    s.wready  <= 1'b1;
                    if (aw_done_c && w_done_c) begin
                        s.awready <= 1'b0;
                        s.wready  <= 1'b0;
                        s.bvalid  <= 1'b1;
                        s.bresp   <= wr_resp_c;
                        w_state   <= W_RESP;
                    end else if (aw_done_c) begin
                        aw_addr_q <= s.awaddr;
                        s.awready <= 1'b0;
                        w_state   <= W_HAVE_A;
                    end else if (w_done_c) begin
                        w_data_q <= s.wdata;
                        w_strb_q <= s.wstrb;
                        s.wready <= 1'b0;
                        w_state  <= W_HAVE_D;
                    end
                end
                W_HAVE_A: begin
                    if (w_done_c) begin
                        s.wready <= 1'b0;
                        s.bvalid <= 1'b1;
                        s.bresp  <= wr_resp_c;
                        w_state  <= W_RESP;
                    end
                end
                W_HAVE_D: begin
                    if (aw_done_c) begin
                        s.awready <= 1'b0;
                        s.bvalid  <= 1'b1;
                        s.bresp   <= wr_resp_c;
                        w_state   <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_done_c) begin
                        s.bvalid  <= 1'b0;
                        s.awready <= 1'b1;
                        s.wready  <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM; samples the register before any same-edge update.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= R_IDLE;
            s.arready <= 1'b0;
            s.rvalid  <= 1'b0;
            s.rresp   <= AXI_RESP_OKAY;
            s.rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s.arready <= 1'b1;
                    if (ar_done_c) begin
                        s.arready <= 1'b0;
                        s.rvalid  <= 1'b1;
                        s.rresp   <= rd_err_c ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        s.rdata   <= rd_err_c ? '0 : rd_word_c;
                        r_state   <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (r_done_c) begin
                        s.rvalid  <= 1'b0;
                        s.arready <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Register array: an AXI commit owns the whole word, so a same-index hw write is dropped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            regs_out <= {NREGS{RESET_VAL}};
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (wr_fire_c && !wr_err_c && wr_idx_c == AWIDTH'(i)) begin
                    for (int unsigned b = 0; b < NBYTES; b++) begin
                        if (wr_strb_c[b]) regs_out[i*DWIDTH + b*8 +: 8] <= wr_data_c[b*8 +: 8];
                    end
                end else if (hw_we && 32'(hw_idx) == i) begin
                    regs_out[i*DWIDTH +: DWIDTH] <= hw_wdata;
                end
            end
        end
    end

endmodule

// File: doc/axi4lite_reg_target.md
Name: axi4lite_reg_target

Overview:
AXI4-Lite register-bank responder that attaches to the target_port modport of axi4lite_if. It holds NREGS word-wide control registers that a master can read and write. It exposes the registers flat to surrounding RTL, and provides a hardware-side write port for status updates. It sits behind an interconnect or directly under a SystemC bridge in the example RTL.

Parameters:
- AWIDTH, 32, address width; must match the connected axi4lite_if.
- DWIDTH, 32, data width; 32 or 64 only.
- NREGS, 16, number of registers; 1..256.
- RESET_VAL, 0, reset value of every register (DWIDTH bits).

Ports:
- clk  input  1  clock; all logic on rising edge.
- resetn  input  1  synchronous active-low reset.
- s  interface  -  axi4lite_if.target_port (AWIDTH, DWIDTH), AXI4-Lite target side.
- regs_out  output  NREGS*DWIDTH  register contents; reg i is at bits [i*DWIDTH +: DWIDTH].
- hw_we  input  1  hardware write enable.
- hw_idx  input  8  hardware write register index.
- hw_wdata  input  DWIDTH  hardware write data (full word).

Behaviour:
- Reset (resetn=0 at a clk edge):
  - awready, wready, arready, bvalid, rvalid = 0.
  - bresp, rresp = 2'b00; rdata = 0.
  - All registers = RESET_VAL.
  - Write and read FSMs go to IDLE.
  - Readies rise on the first edge after resetn=1.
  - Reset mid-transaction drops the pending response; no partial write is committed.
- Decode:
  - idx = addr >> log2(DWIDTH/8); low byte-offset bits are ignored.
  - idx >= NREGS is an error: resp SLVERR (2'b10), no register change, rdata = 0.
  - Otherwise resp is OKAY (2'b00).
  - awprot/arprot are ignored unless the optional feature is compiled in.
- Write FSM, states W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP. All outputs are registered.
  - W_IDLE: awready=wready=1.
    - awdone & wdone -> commit, go to W_RESP.
    - awdone only -> latch addr, go to W_HAVE_A.
    - wdone only -> latch data and strb, go to W_HAVE_D.
  - W_HAVE_A: awready=0, wready=1. wdone -> commit, go to W_RESP.
  - W_HAVE_D: wready=0, awready=1. awdone -> commit, go to W_RESP.
  - Commit: byte lanes with wstrb[b]=1 are updated; other lanes are unchanged. wstrb=0 is a legal no-op with OKAY.
  - W_RESP: bvalid=1 from the edge after the last handshake (1-cycle latency); awready=wready=0; bresp holds until bdone, then go to W_IDLE.
  - bvalid and bresp stay stable while bready=0.
- Read FSM, states R_IDLE, R_RESP.
  - R_IDLE: arready=1. ardone -> sample register (pre-update value), go to R_RESP.
  - R_RESP: rvalid=1 on the next edge; arready=0. rdata and rresp stay stable until rdone, then go to R_IDLE.
- Channel independence and throughput:
  - The read and write FSMs are fully independent.
  - A read and a write commit to the same register in the same cycle: the read returns the old value.
  - Maximum throughput is one transaction per 2 cycles per direction; there is no outstanding-transaction queue.
- Hardware write port:
  - hw_we with hw_idx < NREGS writes the full word.
  - hw_idx >= NREGS is ignored.
  - An AXI commit to the same index in the same cycle takes precedence for the whole register; the hw write is dropped.
  - regs_out reflects updates one cycle after commit.

Optional Feature:
- Macro: AXI4LITE_REG_TARGET_PROT_CHECK_EN.
- Defined: accesses with awprot[1]=1 or arprot[1]=1 (non-secure) to index 0 are treated like an out-of-range access: SLVERR, no write, rdata=0. Other indices are unaffected.
- Undefined: prot is ignored entirely and no extra logic is generated.

Decomposition:
- Package axi4lite_pkg holds:
  - resp constants AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10.
  - typedef enums wr_state_t {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} and rd_state_t {R_IDLE, R_RESP}.
- No sub-module is needed; a single module with two FSM processes plus a register-array process is natural.

Test Plan:
- Reset: after reset release, read idx 3 (addr 0x0C) -> rvalid 1 cycle after ardone, rdata=RESET_VAL, rresp=OKAY.
- Aligned write: AW and W in the same cycle, addr 0x08, data 0xDEADBEEF, strb 4'hF -> bvalid next cycle, OKAY. Readback 0xDEADBEEF; regs_out[95:64]=0xDEADBEEF.
- Split channels with strobes: W first (0x11223344, strb 4'b0101), AW 3 cycles later to 0x04 with bready held low 5 cycles -> bvalid stable for the whole stall. reg1 = 0x00220044 from reset 0.
- Out of range: write and read to addr 0x40 with NREGS=16 -> both SLVERR, rdata=0, no register changes.
- Collision: hw_we on idx 2 with 0x5 in the same cycle as an AXI commit of 0xA to idx 2 -> reg2=0xA. A read issued in that cycle returns the prior value.
- Mid-transaction reset: assert resetn=0 during W_RESP -> bvalid=0 next edge, all registers = RESET_VAL.
